// File: rtl/prores_seq_pkg.sv
// Shared types and default timing for the slice back-end sequencer.
// Phase lengths are expressed per block so the controller can size each phase from the latched count.
package prores_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DCT    = 3'd1,
    ST_DC_RUN = 3'd2,
    ST_AC_RUN = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int AC_COEFS_PER_BLOCK = 63;
  localparam int DC_PER_BLOCK       = 1;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_DCT_LAT    = 10;
  localparam int DEF_DC_PIPE    = 6;
  localparam int DEF_AC_PIPE    = 5;
  localparam int DEF_MAX_BLOCKS = 32;

endpackage

// File: rtl/slice_phase_controller_phase_timer.sv
// Phase counter shared by all timed states: clears on state entry, loads that state's length,
// and flags the last cycle of the phase.
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count_next,
  output logic             terminal
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] limit_reg;

  always_comb begin
    count_next = clear ? '0 : count_reg + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      limit_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (clear) begin
        limit_reg <= limit;
      end
    end
  end

  // Last cycle of the current phase; meaningless in IDLE where the limit is not used.
  assign terminal = (count_reg == limit_reg - CNT_W'(1));

endmodule

// File: rtl/slice_phase_controller.sv
// Sequences one slice through DCT settle, DC VLC, AC VLC and flush with a start/busy/done handshake.
// Every output is a registered Moore output derived from the next state and next phase count.
module slice_phase_controller
  import prores_seq_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DCT_LAT    = DEF_DCT_LAT,
  parameter int DC_PIPE    = DEF_DC_PIPE,
  parameter int AC_PIPE    = DEF_AC_PIPE,
  parameter int MAX_BLOCKS = DEF_MAX_BLOCKS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             slice_start,
  input  logic [CNT_W-1:0] block_num,
  output logic             busy,
  output logic             start_error,
  output logic             dc_vlc_reset,
  output logic             dc_vlc_output_enable,
  output logic [CNT_W-1:0] dc_vlc_counter,
  output logic             ac_vlc_reset,
  output logic             ac_vlc_output_enable,
  output logic             ac_vlc_output_flush,
  output logic [CNT_W-1:0] ac_vlc_counter,
  output logic             slice_done
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] blk_q;
  logic [CNT_W-1:0] pc_next;
  logic [CNT_W-1:0] limit_next;
  logic [CNT_W-1:0] dc_len;
  logic [CNT_W-1:0] ac_len;
  logic             pc_terminal;
  logic             phase_clear;
  logic             start_legal;
  logic             accept;

  logic             busy_next;
  logic             start_error_next;
  logic             dc_vlc_reset_next;
  logic             dc_vlc_output_enable_next;
  logic [CNT_W-1:0] dc_vlc_counter_next;
  logic             ac_vlc_reset_next;
  logic             ac_vlc_output_enable_next;
  logic             ac_vlc_output_flush_next;
  logic [CNT_W-1:0] ac_vlc_counter_next;
  logic             slice_done_next;

  assign start_legal = (block_num != '0) && (block_num <= CNT_W'(MAX_BLOCKS));
  assign accept      = slice_start && start_legal && (state_reg == ST_IDLE);

  // Largest AC length is 63 * MAX_BLOCKS, well inside CNT_W.
  assign dc_len = CNT_W'(DC_PIPE) + CNT_W'(DC_PER_BLOCK) * blk_q;
  assign ac_len = CNT_W'(AC_PIPE) + CNT_W'(AC_COEFS_PER_BLOCK) * blk_q;

  assign phase_clear = (state_next != state_reg);

  always_comb begin
    case (state_next)
      ST_DCT:    limit_next = CNT_W'(DCT_LAT);
      ST_DC_RUN: limit_next = dc_len;
      ST_AC_RUN: limit_next = ac_len;
      default:   limit_next = CNT_W'(1);
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (phase_clear),
    .limit      (limit_next),
    .count_next (pc_next),
    .terminal   (pc_terminal)
  );

  // State, latched block count and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg            <= ST_IDLE;
      blk_q                <= '0;
      busy                 <= 1'b0;
      start_error          <= 1'b0;
      dc_vlc_reset         <= 1'b0;
      dc_vlc_output_enable <= 1'b0;
      dc_vlc_counter       <= '0;
      ac_vlc_reset         <= 1'b0;
      ac_vlc_output_enable <= 1'b0;
      ac_vlc_output_flush  <= 1'b0;
      ac_vlc_counter       <= '0;
      slice_done           <= 1'b0;
    end else begin
      state_reg            <= state_next;
      if (accept) begin
        blk_q <= block_num;
      end
      busy                 <= busy_next;
      start_error          <= start_error_next;
      dc_vlc_reset         <= dc_vlc_reset_next;
      dc_vlc_output_enable <= dc_vlc_output_enable_next;
      dc_vlc_counter       <= dc_vlc_counter_next;
      ac_vlc_reset         <= ac_vlc_reset_next;
      ac_vlc_output_enable <= ac_vlc_output_enable_next;
      ac_vlc_output_flush  <= ac_vlc_output_flush_next;
      ac_vlc_counter       <= ac_vlc_counter_next;
      slice_done           <= slice_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept)      state_next = ST_DCT;
      ST_DCT:    if (pc_terminal) state_next = ST_DC_RUN;
      ST_DC_RUN: if (pc_terminal) state_next = ST_AC_RUN;
      ST_AC_RUN: if (pc_terminal) state_next = ST_FLUSH;
      ST_FLUSH:                   state_next = ST_DONE;
      ST_DONE:                    state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they switch on the same edge as the state.
  always_comb begin
    busy_next                 = (state_next != ST_IDLE);
    start_error_next          = slice_start && !accept;
    dc_vlc_reset_next         = 1'b0;
    dc_vlc_output_enable_next = 1'b0;
    dc_vlc_counter_next       = '0;
    ac_vlc_reset_next         = 1'b0;
    ac_vlc_output_enable_next = 1'b0;
    ac_vlc_output_flush_next  = 1'b0;
    ac_vlc_counter_next       = '0;
    slice_done_next           = 1'b0;
    case (state_next)
      ST_DC_RUN: begin
        dc_vlc_reset_next         = 1'b1;
        dc_vlc_counter_next       = pc_next;
        dc_vlc_output_enable_next = (pc_next >= CNT_W'(DC_PIPE)) && (pc_next < dc_len);
      end
      ST_AC_RUN: begin
        ac_vlc_reset_next         = 1'b1;
        ac_vlc_counter_next       = pc_next;
        ac_vlc_output_enable_next = (pc_next >= CNT_W'(AC_PIPE)) && (pc_next < ac_len);
      end
      ST_FLUSH: begin
        ac_vlc_reset_next        = 1'b1;
        ac_vlc_output_flush_next = 1'b1;
      end
      ST_DONE: begin
        slice_done_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_slice_phase_controller.sv
// Directed bench for slice_phase_controller: per-cycle comparison against a timing model written
// from the slice timeline, plus table-driven totals and hand sequences for reset and held starts.
module tb_slice_phase_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        slice_start = 1'b0;
  logic [31:0] block_num = '0;
  logic        busy;
  logic        start_error;
  logic        dc_vlc_reset;
  logic        dc_vlc_output_enable;
  logic [31:0] dc_vlc_counter;
  logic        ac_vlc_reset;
  logic        ac_vlc_output_enable;
  logic        ac_vlc_output_flush;
  logic [31:0] ac_vlc_counter;
  logic        slice_done;

  int checks = 0;
  int errors = 0;

  slice_phase_controller dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .slice_start          (slice_start),
    .block_num            (block_num),
    .busy                 (busy),
    .start_error          (start_error),
    .dc_vlc_reset         (dc_vlc_reset),
    .dc_vlc_output_enable (dc_vlc_output_enable),
    .dc_vlc_counter       (dc_vlc_counter),
    .ac_vlc_reset         (ac_vlc_reset),
    .ac_vlc_output_enable (ac_vlc_output_enable),
    .ac_vlc_output_flush  (ac_vlc_output_flush),
    .ac_vlc_counter       (ac_vlc_counter),
    .slice_done           (slice_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int bn;
    bit accept;
    int dc_en_n;
    int ac_en_n;
    int done_at;
    int ac_max;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] flags();
    return {busy, start_error, dc_vlc_reset, dc_vlc_output_enable,
            ac_vlc_reset, ac_vlc_output_enable, ac_vlc_output_flush, slice_done};
  endfunction

  task automatic check_value(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic exp_err);
    logic [7:0] ef;
    ef = {1'b0, exp_err, 6'b0};
    checks++;
    if (flags() !== ef || dc_vlc_counter !== 32'd0 || ac_vlc_counter !== 32'd0) begin
      errors++;
      $display("FAIL %s got flags=%b dc=%0d ac=%0d required flags=%b dc=0 ac=0",
               name, flags(), dc_vlc_counter, ac_vlc_counter, ef);
    end else begin
      $display("ok   %s flags=%b", name, flags());
    end
  endtask

  // Called #1 after the accept edge E0; walks cycles k = 0 .. done+1 comparing every output.
  task automatic check_slice(input int b, input bit hold_err, input string name,
                             output int dc_n, output int ac_n, output int done_at,
                             output int ac_max);
    int         t_done;
    int         bad;
    logic [7:0] ef;
    logic [31:0] edc;
    logic [31:0] eac;
    t_done  = 22 + 64 * b;
    dc_n    = 0;
    ac_n    = 0;
    done_at = -1;
    ac_max  = 0;
    bad     = 0;
    for (int k = 0; k <= t_done + 1; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      ef = {k <= t_done,
            hold_err && (k >= 1) && (k <= t_done + 1),
            (k >= 10) && (k <= 15 + b),
            (k >= 16) && (k <= 15 + b),
            (k >= 16 + b) && (k <= 21 + 64 * b),
            (k >= 21 + b) && (k <= 20 + 64 * b),
            k == 21 + 64 * b,
            k == t_done};
      edc = ((k >= 10) && (k <= 15 + b)) ? 32'(k - 10) : 32'd0;
      eac = ((k >= 16 + b) && (k <= 20 + 64 * b)) ? 32'(k - 16 - b) : 32'd0;
      checks++;
      if (flags() !== ef || dc_vlc_counter !== edc || ac_vlc_counter !== eac) begin
        errors++;
        bad++;
        $display("FAIL %s cycle %0d got flags=%b dc=%0d ac=%0d required flags=%b dc=%0d ac=%0d",
                 name, k, flags(), dc_vlc_counter, ac_vlc_counter, ef, edc, eac);
      end
      if (dc_vlc_output_enable) dc_n++;
      if (ac_vlc_output_enable) ac_n++;
      if (slice_done && done_at < 0) done_at = k;
      if (int'(ac_vlc_counter) > ac_max) ac_max = int'(ac_vlc_counter);
    end
    $display("ok   %s b=%0d cycles=%0d cycle_mismatches=%0d", name, b, t_done + 2, bad);
  endtask

  task automatic check_totals(input string name, input vec_t v, input int dc_n, input int ac_n,
                              input int done_at, input int ac_max);
    check_value({name, " dc_enable_cycles"}, dc_n, v.dc_en_n);
    check_value({name, " ac_enable_cycles"}, ac_n, v.ac_en_n);
    check_value({name, " done_cycle"}, done_at, v.done_at);
    check_value({name, " ac_counter_max"}, ac_max, v.ac_max);
  endtask

  initial begin
    int   dc_n;
    int   ac_n;
    int   done_at;
    int   ac_max;
    int   extra;
    vec_t v;

    vecs[0] = '{bn: 4,  accept: 1'b1, dc_en_n: 4,  ac_en_n: 252,  done_at: 278,  ac_max: 256};
    vecs[1] = '{bn: 1,  accept: 1'b1, dc_en_n: 1,  ac_en_n: 63,   done_at: 86,   ac_max: 67};
    vecs[2] = '{bn: 0,  accept: 1'b0, dc_en_n: 0,  ac_en_n: 0,    done_at: 0,    ac_max: 0};
    vecs[3] = '{bn: 33, accept: 1'b0, dc_en_n: 0,  ac_en_n: 0,    done_at: 0,    ac_max: 0};
    vecs[4] = '{bn: 32, accept: 1'b1, dc_en_n: 32, ac_en_n: 2016, done_at: 2070, ac_max: 2020};
    vecs[5] = '{bn: 7,  accept: 1'b1, dc_en_n: 7,  ac_en_n: 441,  done_at: 470,  ac_max: 445};

    // Reset state, with a start request asserted during reset.
    slice_start = 1'b1;
    block_num   = 32'd4;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset_state", 1'b0);
    @(negedge clock);
    slice_start = 1'b0;
    reset_n     = 1'b1;
    @(posedge clock);
    #1;
    check_idle_outputs("after_release", 1'b0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      @(negedge clock);
      slice_start = 1'b1;
      block_num   = 32'(v.bn);
      @(posedge clock);
      #1;
      slice_start = 1'b0;
      block_num   = 32'hDEAD_BEEF;
      if (v.accept) begin
        check_slice(v.bn, 1'b0, $sformatf("vec%0d", i), dc_n, ac_n, done_at, ac_max);
        check_totals($sformatf("vec%0d", i), v, dc_n, ac_n, done_at, ac_max);
      end else begin
        check_idle_outputs($sformatf("vec%0d reject_pulse", i), 1'b1);
        @(posedge clock);
        #1;
        check_idle_outputs($sformatf("vec%0d reject_after", i), 1'b0);
      end
    end

    // slice_start held through a whole b=2 slice; second slice picks up block_num=3.
    @(negedge clock);
    slice_start = 1'b1;
    block_num   = 32'd2;
    @(posedge clock);
    #1;
    block_num = 32'd3;
    check_slice(2, 1'b1, "held_first", dc_n, ac_n, done_at, ac_max);
    check_value("held_first done_cycle", done_at, 150);
    @(posedge clock);
    #1;
    slice_start = 1'b0;
    check_slice(3, 1'b0, "held_second", dc_n, ac_n, done_at, ac_max);
    check_value("held_second done_cycle", done_at, 214);
    check_value("held_second dc_enable_cycles", dc_n, 3);

    // Asynchronous reset during AC_RUN of a b=32 slice.
    @(negedge clock);
    slice_start = 1'b1;
    block_num   = 32'd32;
    @(posedge clock);
    #1;
    slice_start = 1'b0;
    repeat (148) @(posedge clock);
    #1;
    check_value("abort ac_reset_before", int'(ac_vlc_reset), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort async_clear", 1'b0);
    extra = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (ac_vlc_output_flush || slice_done || busy) extra++;
    end
    check_value("abort no_flush_done", extra, 0);
    @(negedge clock);
    reset_n     = 1'b1;
    slice_start = 1'b1;
    block_num   = 32'd1;
    @(posedge clock);
    #1;
    slice_start = 1'b0;
    check_slice(1, 1'b0, "after_abort", dc_n, ac_n, done_at, ac_max);
    check_totals("after_abort", vecs[1], dc_n, ac_n, done_at, ac_max);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_phase_controller.md
Name: slice_phase_controller

Overview:
FSM-based scheduler that sequences one slice through the encoder back end: DCT settle window, then the DC VLC phase, then the AC VLC phase and a final flush. It replaces free-running-counter/compare timing with explicit phases, a start/busy/done handshake and per-phase counters. The VLC reset, enable, flush and counter controls from this block drive the DC VLC and AC VLC stages directly.

Parameters:
CNT_W, 32, width of block_num, phase counter and exported VLC counters
DCT_LAT, 10, cycles from slice accept until DC VLC reset release
DC_PIPE, 6, DC VLC cycles from reset release to first valid output
AC_PIPE, 5, AC VLC cycles from reset release to first valid output
MAX_BLOCKS, 32, largest legal block_num

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous, active-low reset
slice_start  in  1  single-cycle request to start a slice
block_num  in  CNT_W  blocks in the slice; sampled only when a start is accepted
busy  out  1  high while a slice is in progress (state != IDLE)
start_error  out  1  one-cycle pulse when a start is rejected
dc_vlc_reset  out  1  active-low reset to DC VLC (1 = running)
dc_vlc_output_enable  out  1  DC VLC output valid window
dc_vlc_counter  out  CNT_W  cycle index within DC phase
ac_vlc_reset  out  1  active-low reset to AC VLC (1 = running)
ac_vlc_output_enable  out  1  AC VLC output valid window
ac_vlc_output_flush  out  1  one-cycle AC bit-packer flush
ac_vlc_counter  out  CNT_W  cycle index within AC phase
slice_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; every output 0, counters 0, latched block count 0. Reset mid-slice aborts immediately, with no flush or done pulse.
- All outputs are registered Moore outputs. They change on the same edge as the state.
- States: IDLE, DCT, DC_RUN, AC_RUN, FLUSH, DONE.
- Phase counter: pc clears to 0 on every state entry and increments each cycle.
- IDLE:
  - slice_start with 1 <= block_num <= MAX_BLOCKS: latch blk_q, go to DCT.
  - slice_start with block_num = 0 or > MAX_BLOCKS: start_error pulse, stay IDLE.
- Any state other than IDLE: slice_start is ignored and produces a start_error pulse. This includes the DONE cycle.
- DCT: both VLC resets 0. After DCT_LAT cycles (pc = DCT_LAT-1), go to DC_RUN.
- DC_RUN:
  - dc_vlc_reset = 1; dc_vlc_counter = pc.
  - dc_vlc_output_enable = 1 for pc in [DC_PIPE, DC_PIPE+blk_q-1].
  - Lasts DC_PIPE+blk_q cycles, then AC_RUN; dc_vlc_reset returns to 0.
- AC_RUN:
  - ac_vlc_reset = 1; ac_vlc_counter = pc.
  - ac_vlc_output_enable = 1 for pc in [AC_PIPE, AC_PIPE+63*blk_q-1].
  - Lasts AC_PIPE+63*blk_q cycles, then FLUSH.
- FLUSH: one cycle; ac_vlc_output_flush = 1, ac_vlc_reset stays 1, enable 0.
- DONE: one cycle; slice_done = 1, ac_vlc_reset 0, busy still 1. Next state IDLE.
- Counters outside their own phase read 0.
- Arithmetic: 63*blk_q is computed in CNT_W bits; the maximum is 2016, so there is no overflow.
- Timing: with accept edge E0 and blk=b, slice_done is high for the cycle starting at E0 + DCT_LAT + DC_PIPE + 64b + AC_PIPE + 1. busy drops one cycle later.
- Back-to-back: a new start is accepted on the first IDLE cycle.

Decomposition:
- Package prores_seq_pkg:
  - state enum
  - AC_COEFS_PER_BLOCK = 63, DC_PER_BLOCK = 1
  - default DCT_LAT, DC_PIPE, AC_PIPE, MAX_BLOCKS
- Sub-module phase_timer: CNT_W counter with clear-on-entry and terminal-count compare against a loaded limit. It is shared by all timed states.

Test Plan:
- b=4, start at E0 (defaults) -> busy E0..E278:
  - dc_vlc_reset high E10..E19; dc enable high E16..E19, i.e. 4 cycles, dc counter 6..9.
  - ac_vlc_reset high E20..E277; ac enable E25..E276 (252 cycles).
  - flush at E277; slice_done at E278; busy 0 at E279.
- b=1 -> dc enable 1 cycle (counter 6); ac enable 63 cycles; slice_done at E0+10+6+1+5+63+1 = E86.
- block_num=0, then block_num=33 -> start_error pulse each; busy stays 0; no VLC output changes.
- slice_start held high through a whole slice, b=2 -> start_error each busy cycle; second slice accepted on first IDLE cycle; its blk_q = block_num at that edge.
- reset_n low during AC_RUN with b=32 -> all outputs 0 asynchronously; no flush or done; a fresh start after release times correctly.
- b=32 -> ac enable exactly 2016 cycles; ac_vlc_counter reaches 2020 with no wrap.
